// File: rtl/matrix_mult_engine.sv
// Streaming matrix multiplier: buffers A then B from one input stream, then
// computes C = A x B with a single MAC and streams C out row-major.
module matrix_mult_engine #(
    parameter int ROWS_A            = 8,
    parameter int COLS_A            = 8,
    parameter int COLS_B            = 8,
    parameter int INPUT_DATA_WIDTH  = 8,
    parameter int OUTPUT_DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         signed_mode,
    input  logic [INPUT_DATA_WIDTH-1:0]  in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [OUTPUT_DATA_WIDTH-1:0] out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last,
    output logic                         busy,
    output logic                         done
);
    localparam int W   = INPUT_DATA_WIDTH;
    localparam int OW  = OUTPUT_DATA_WIDTH;
    localparam int PW  = 2*W + 2;
    localparam int NA  = ROWS_A*COLS_A;
    localparam int NB  = COLS_A*COLS_B;
    localparam int AAW = (NA > 1) ? $clog2(NA) : 1;
    localparam int BAW = (NB > 1) ? $clog2(NB) : 1;
    localparam int LW  = (AAW > BAW) ? AAW : BAW;
    localparam int IW  = (ROWS_A > 1) ? $clog2(ROWS_A) : 1;
    localparam int KW  = (COLS_A > 1) ? $clog2(COLS_A) : 1;
    localparam int JW  = (COLS_B > 1) ? $clog2(COLS_B) : 1;

    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, COMPUTE, OUTPUT} state_t;

    state_t          state, state_nxt;
    logic [W-1:0]    a_mem [NA];
    logic [W-1:0]    b_mem [NB];
    logic [LW-1:0]   ld_cnt;
    logic [IW-1:0]   i_cnt;
    logic [KW-1:0]   k_cnt;
    logic [JW-1:0]   j_cnt;
    logic            sm_q;
    logic [OW-1:0]   acc, sum;
    logic [W-1:0]    a_op, b_op;
    logic signed [W:0]    a_x, b_x;
    logic signed [PW-1:0] prod;
    logic            in_hs, out_hs, a_last, b_last, i_last, j_last, k_last;

    assign in_hs  = in_valid & in_ready;
    assign out_hs = out_valid & out_ready;
    assign busy   = (state != IDLE);
    assign a_last = (ld_cnt == LW'(NA-1));
    assign b_last = (ld_cnt == LW'(NB-1));
    assign i_last = (i_cnt == IW'(ROWS_A-1));
    assign j_last = (j_cnt == JW'(COLS_B-1));
    assign k_last = (k_cnt == KW'(COLS_A-1));

    // One extra bit per operand lets a single signed multiplier serve both
    // modes: the top bit is the sign in signed mode and zero otherwise.
    always_comb begin
        a_op = a_mem[AAW'(32'(i_cnt) * COLS_A + 32'(k_cnt))];
        b_op = b_mem[BAW'(32'(k_cnt) * COLS_B + 32'(j_cnt))];
        a_x  = {sm_q & a_op[W-1], a_op};
        b_x  = {sm_q & b_op[W-1], b_op};
        prod = PW'(a_x) * PW'(b_x);
        sum  = ((k_cnt == '0) ? '0 : acc) + OW'(prod);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_hs) state_nxt = (NA == 1) ? LOAD_B : LOAD_A;
            LOAD_A:  if (in_hs && a_last) state_nxt = LOAD_B;
            LOAD_B:  if (in_hs && b_last) state_nxt = COMPUTE;
            COMPUTE: if (k_last) state_nxt = OUTPUT;
            OUTPUT:  if (out_hs) state_nxt = (i_last && j_last) ? IDLE : COMPUTE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand buffers carry no reset; stale contents are overwritten per job.
    always_ff @(posedge clk) begin
        if (in_hs && state != LOAD_B) a_mem[AAW'(ld_cnt)] <= in_data;
        if (in_hs && state == LOAD_B) b_mem[BAW'(ld_cnt)] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_cnt    <= '0;
            i_cnt     <= '0;
            j_cnt     <= '0;
            k_cnt     <= '0;
            acc       <= '0;
            sm_q      <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            in_ready <= (state_nxt == IDLE) || (state_nxt == LOAD_A) || (state_nxt == LOAD_B);
            done     <= 1'b0;
            unique case (state)
                IDLE: if (in_hs) begin
                    sm_q   <= signed_mode;
                    ld_cnt <= (NA == 1) ? '0 : LW'(1);
                end
                LOAD_A: if (in_hs) ld_cnt <= a_last ? '0 : ld_cnt + LW'(1);
                LOAD_B: if (in_hs) ld_cnt <= b_last ? '0 : ld_cnt + LW'(1);
                COMPUTE: begin
                    acc <= sum;
                    if (k_last) begin
                        k_cnt     <= '0;
                        out_data  <= sum;
                        out_valid <= 1'b1;
                        out_last  <= i_last && j_last;
                    end else begin
                        k_cnt <= k_cnt + KW'(1);
                    end
                end
                OUTPUT: if (out_hs) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    if (j_last) begin
                        j_cnt <= '0;
                        i_cnt <= i_last ? '0 : i_cnt + IW'(1);
                        done  <= i_last;
                    end else begin
                        j_cnt <= j_cnt + JW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_mult_engine.sv
// Directed bench: three engine configurations share one stimulus driver,
// selected by sel; expected results are hand-computed tables.
module tb_matrix_mult_engine;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, t_signed, t_in_valid, t_out_ready;
    logic [7:0]  t_in_data;
    int          sel;
    int          errors = 0;
    int          checks = 0;

    logic        ir0, ov0, ol0, bz0, dn0;
    logic        ir1, ov1, ol1, bz1, dn1;
    logic        ir2, ov2, ol2, bz2, dn2;
    logic [31:0] od0, od1;
    logic [15:0] od2;
    logic        o_ir, o_ov, o_ol, o_bz, o_dn;
    logic [31:0] o_od;

    logic [7:0]  stim[$];
    logic [31:0] expq[$];

    matrix_mult_engine u_dut (
        .clk(clk), .rst_n(rst_n), .signed_mode(t_signed), .in_data(t_in_data),
        .in_valid(t_in_valid && sel == 0), .in_ready(ir0), .out_data(od0), .out_valid(ov0),
        .out_ready(t_out_ready && sel == 0), .out_last(ol0), .busy(bz0), .done(dn0));

    matrix_mult_engine #(.ROWS_A(2), .COLS_A(3), .COLS_B(4)) u_small (
        .clk(clk), .rst_n(rst_n), .signed_mode(t_signed), .in_data(t_in_data),
        .in_valid(t_in_valid && sel == 1), .in_ready(ir1), .out_data(od1), .out_valid(ov1),
        .out_ready(t_out_ready && sel == 1), .out_last(ol1), .busy(bz1), .done(dn1));

    matrix_mult_engine #(.OUTPUT_DATA_WIDTH(16)) u_ovf (
        .clk(clk), .rst_n(rst_n), .signed_mode(t_signed), .in_data(t_in_data),
        .in_valid(t_in_valid && sel == 2), .in_ready(ir2), .out_data(od2), .out_valid(ov2),
        .out_ready(t_out_ready && sel == 2), .out_last(ol2), .busy(bz2), .done(dn2));

    always_comb begin
        case (sel)
            1: begin o_ir = ir1; o_ov = ov1; o_ol = ol1; o_bz = bz1; o_dn = dn1; o_od = od1; end
            2: begin o_ir = ir2; o_ov = ov2; o_ol = ol2; o_bz = bz2; o_dn = dn2; o_od = {16'h0, od2}; end
            default: begin o_ir = ir0; o_ov = ov0; o_ol = ol0; o_bz = bz0; o_dn = dn0; o_od = od0; end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic fill_const(input int na, input int nb, input logic [7:0] va,
                              input logic [7:0] vb, input logic [31:0] e, input int ne);
        stim.delete();
        expq.delete();
        repeat (na) stim.push_back(va);
        repeat (nb) stim.push_back(vb);
        repeat (ne) expq.push_back(e);
    endtask

    task automatic fill_ident();
        stim.delete();
        expq.delete();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) stim.push_back((r == c) ? 8'd1 : 8'd0);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                stim.push_back(8'(8*r + c));
                expq.push_back(32'(8*r + c));
            end
    endtask

    task automatic fill_small();
        logic [7:0]  a_tab [6]  = '{1, 2, 3, 4, 5, 6};
        logic [7:0]  b_tab [12] = '{1, 0, 0, 1, 0, 1, 0, 1, 0, 0, 1, 1};
        logic [31:0] c_tab [8]  = '{1, 2, 3, 6, 4, 5, 6, 15};
        stim.delete();
        expq.delete();
        foreach (a_tab[n]) stim.push_back(a_tab[n]);
        foreach (b_tab[n]) stim.push_back(b_tab[n]);
        foreach (c_tab[n]) expq.push_back(c_tab[n]);
    endtask

    // signed_mode flips after the first beat: only the first beat's value may matter.
    task automatic feed(input int gap, input logic sm);
        int w;
        for (int n = 0; n < stim.size(); n++) begin
            while ($urandom_range(99) < gap) begin
                t_in_valid = 1'b0;
                @(negedge clk);
            end
            t_in_valid = 1'b1;
            t_in_data  = stim[n];
            t_signed   = (n == 0) ? sm : ~sm;
            w = 0;
            while (!o_ir && w < 5000) begin
                @(negedge clk);
                w++;
            end
            if (w >= 5000) begin
                chk("in_ready_timeout", 32'(o_ir), 32'd1);
                break;
            end
            @(negedge clk);
        end
        t_in_valid = 1'b0;
    endtask

    task automatic consume(input int nout, input int stall, input bit chk_done, input string tag);
        int          got, cyc, dcnt;
        logic        held, hl;
        logic [31:0] hd;
        got = 0; cyc = 0; dcnt = 0; held = 1'b0; hl = 1'b0; hd = '0;
        while (got < nout && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (o_dn) dcnt++;
            if (held) begin
                chk({tag, "_hold_data"}, o_od, hd);
                chk({tag, "_hold_vl"}, {30'h0, o_ov, o_ol}, {30'h0, 1'b1, hl});
            end
            t_out_ready = ($urandom_range(99) >= stall);
            held = 1'b0;
            if (o_ov) begin
                if (t_out_ready) begin
                    chk($sformatf("%s_data%0d", tag, got), o_od, expq[got]);
                    chk($sformatf("%s_last%0d", tag, got), 32'(o_ol), 32'(got == expq.size() - 1));
                    got++;
                end else begin
                    held = 1'b1;
                    hd   = o_od;
                    hl   = o_ol;
                end
            end
        end
        if (got < nout) chk({tag, "_out_timeout"}, 32'(got), 32'(nout));
        @(negedge clk);
        if (o_dn) dcnt++;
        t_out_ready = 1'b0;
        if (chk_done) chk({tag, "_done_pulses"}, 32'(dcnt), 32'd1);
    endtask

    task automatic run(input int s, input int gap, input int stall, input logic sm, input string tag);
        sel = s;
        fork
            feed(gap, sm);
            consume(expq.size(), stall, 1'b1, tag);
        join
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; sel = 0; t_signed = 1'b0; t_in_valid = 1'b0;
        t_out_ready = 1'b0; t_in_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(o_ov), 32'd0);
        chk("rst_out_data", o_od, 32'd0);
        chk("rst_out_last", 32'(o_ol), 32'd0);
        chk("rst_in_ready", 32'(o_ir), 32'd0);
        chk("rst_busy", 32'(o_bz), 32'd0);
        chk("rst_done", 32'(o_dn), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_in_ready", 32'(o_ir), 32'd1);
        chk("idle_busy", 32'(o_bz), 32'd0);

        fill_ident();
        run(0, 0, 0, 1'b0, "ident");
        fill_const(64, 64, 8'hFF, 8'hFF, 32'h0007F008, 64);
        run(0, 0, 0, 1'b0, "u255");
        fill_const(64, 64, 8'h80, 8'h80, 32'd131072, 64);
        run(0, 0, 0, 1'b1, "s80");
        fill_const(64, 64, 8'hFF, 8'h05, 32'hFFFFFFD8, 64);
        run(0, 0, 0, 1'b1, "sneg");

        fill_small();
        run(1, 0, 0, 1'b0, "small");
        run(1, 40, 50, 1'b0, "small_bp1");
        run(1, 60, 70, 1'b0, "small_bp2");
        fill_const(64, 64, 8'hFF, 8'hFF, 32'h0007F008, 64);
        run(0, 30, 40, 1'b0, "u255_bp");

        fill_const(64, 64, 8'hFF, 8'hFF, 32'd61448, 64);
        run(2, 0, 0, 1'b0, "ovf16");

        // Abort a job while element 10 is being computed.
        fill_const(64, 64, 8'hFF, 8'hFF, 32'h0007F008, 64);
        sel = 0;
        fork
            feed(0, 1'b0);
            consume(10, 0, 1'b0, "pre_rst");
        join
        repeat (2) @(negedge clk);
        chk("mid_busy", 32'(o_bz), 32'd1);
        chk("mid_in_ready", 32'(o_ir), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_data", o_od, 32'd0);
        chk("mid_rst_out_valid", 32'(o_ov), 32'd0);
        chk("mid_rst_in_ready", 32'(o_ir), 32'd0);
        chk("mid_rst_busy", 32'(o_bz), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fill_ident();
        run(0, 10, 10, 1'b0, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
